reg_scoreboard: RTL

Destination-register scoreboard for the pipelined MIPS core. It takes the 5-bit write-register number chosen by the destination selector (rt, rd or $31) at issue and tracks outstanding writes per architectural register. It retires those writes when write-back reports the same 5-bit register number. Decode queries it with rs/rt to produce a read-after-write stall.

---
 rtl/reg_scoreboard.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// Destination-register scoreboard: per-register outstanding-write counters, RAW stall and busy count.
// Optional macro REG_SCOREBOARD_BYPASS_EN lets a same-cycle final write-back release the stall.
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iss_valid,
  input  logic [4:0] iss_rd,
  output logic       iss_ready,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       stall,
  output logic [5:0] busy_cnt,
  output logic       underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic [31:0]      busy_vec;
  logic [5:0]       busy_nxt;
  logic             underflow_nxt;
  logic             iss_fire;
  logic             wb_fire;

  // A same-register retire frees a slot in the same cycle, so a saturated counter may still accept.
  assign iss_ready = (cnt[iss_rd] != CNT_MAX) || (wb_valid && (wb_rd == iss_rd)) || (iss_rd == 5'd0);
  assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);
  assign wb_fire   = wb_valid && (wb_rd != 5'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    cnt_nxt       = cnt;
    underflow_nxt = 1'b0;
    busy_nxt      = '0;
    for (int r = 1; r < 32; r++) begin
      if (iss_fire && (iss_rd == 5'(r)) && !(wb_fire && (wb_rd == 5'(r)))) begin
        cnt_nxt[r] = cnt[r] + CNT_ONE;
      end else if (wb_fire && (wb_rd == 5'(r)) && !(iss_fire && (iss_rd == 5'(r)))) begin
        if (cnt[r] == '0) underflow_nxt = 1'b1;
        else              cnt_nxt[r]    = cnt[r] - CNT_ONE;
      end
      if (cnt_nxt[r] != '0) busy_nxt = busy_nxt + 6'd1;
    end
    cnt_nxt[0] = '0;
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
`ifdef REG_SCOREBOARD_BYPASS_EN
      // The last outstanding write is being forwarded from write-back right now.
      busy_vec[r] = (cnt[r] != '0) && !(wb_valid && (wb_rd == 5'(r)) && (cnt[r] == CNT_ONE));
`else
      busy_vec[r] = (cnt[r] != '0);
`endif
    end
  end

  assign stall = busy_vec[rs] | busy_vec[rt];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the counters are individual flops rather than a RAM, so they can and must take reset.
      cnt       <= '{default: '0};
      busy_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state, so every flop samples pre-edge values.
      cnt       <= cnt_nxt;
      busy_cnt  <= busy_nxt;
      underflow <= underflow | underflow_nxt;
    end
  end

endmodule
